// File: rtl/edge_event_arbiter.sv
// Edge-event scheduler: per-channel edge detect, one pending slot per channel,
// round-robin onto a valid/ready port. `EDGE_ARB_BOTH_EN adds falling-edge events.
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N-1:0]    din,
    output logic            ev_valid,
    output logic [ID_W-1:0] ev_id,
    output logic            ev_edge,
    input  logic            ev_ready,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow,
    input  logic [N-1:0]    ovf_clr
);

    logic [N-1:0]    prev;
    logic [N-1:0]    evt;
    logic [N-1:0]    pend_clr;
    logic [N-1:0]    pend_hold;
    logic [N-1:0]    drop;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] idx;
    logic            load;

`ifdef EDGE_ARB_BOTH_EN
    assign evt = din ^ prev;
`else
    assign evt = din & ~prev;
`endif

    assign load = (|pending) && (!ev_valid || ev_ready);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        winner = '0;
        idx    = '0;
        // Scan backwards so the closest set bit after last is the one kept.
        for (int k = N; k >= 1; k--) begin
            idx = ID_W'((int'(last) + k) % N);
            if (pending[idx]) winner = idx;
        end
    end

    assign pend_clr  = load ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;
    assign pend_hold = pending & ~pend_clr;
    assign drop      = evt & pend_hold;

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev     <= '0;
            pending  <= '0;
            overflow <= '0;
            last     <= ID_W'(N - 1);
            ev_valid <= 1'b0;
            ev_id    <= '0;
        end else begin
            prev     <= din;
            pending  <= pend_hold | evt;
            // A new drop wins over a clear in the same cycle.
            overflow <= drop | (overflow & ~ovf_clr);
            if (load) begin
                ev_valid <= 1'b1;
                ev_id    <= winner;
                last     <= winner;
            end else if (ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
    end

`ifdef EDGE_ARB_BOTH_EN
    logic [N-1:0] pend_pol;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_pol <= '1;
            ev_edge  <= 1'b1;
        end else begin
            // A dropped edge must not overwrite the polarity of the event still pending.
            for (int i = 0; i < N; i++) begin
                if (evt[i] && !pend_hold[i]) pend_pol[i] <= din[i];
            end
            if (load) ev_edge <= pend_pol[winner];
        end
    end
`else
    assign ev_edge = 1'b1;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios with a scoreboard
// of expected {id, edge} events compared against accepted handshakes.
module tb_edge_event_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic       pol;
    } ev_t;

    logic       clk;
    logic       resetn;
    logic [3:0] din;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic       ev_edge;
    logic       ev_ready;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [3:0] ovf_clr;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    edge_event_arbiter #(.N(4), .ID_W(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .din      (din),
        .ev_valid (ev_valid),
        .ev_id    (ev_id),
        .ev_edge  (ev_edge),
        .ev_ready (ev_ready),
        .pending  (pending),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge sees exactly what the next edge will sample.
    always @(negedge clk) begin
        if (resetn && ev_valid && ev_ready) obs_q.push_back({ev_id, ev_edge});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn   = 1'b0;
        din      = '0;
        ev_ready = 1'b0;
        ovf_clr  = '0;
        tick();
        tick();
        resetn = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        din      = '0;
        ev_ready = 1'b0;
        ovf_clr  = '0;
        tick();
        tick();
        n_checks++;
        if ({ev_valid, ev_id, ev_edge} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_port: valid/id/edge = %b, expected 0001", {ev_valid, ev_id, ev_edge});
        end
        n_checks++;
        if ({pending, overflow} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: pending=%b overflow=%b, expected 0000/0000", pending, overflow);
        end
        resetn = 1'b1;
        tick();
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: ev_valid=%b, expected 0", ev_valid);
        end
    endtask

    task automatic test_single_rise();
        ev_t e, o;
        apply_reset();
        ev_ready = 1'b1;
        din      = 4'b0100;
        exp_q.push_back({2'd2, 1'b1});
        tick();
        n_checks++;
        if (pending !== 4'b0100 || ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t: pending=%b valid=%b, expected 0100/0", pending, ev_valid);
        end
        tick();
        n_checks++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd2 || pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_t1: valid=%b id=%0d pending=%b, expected 1/2/0000", ev_valid, ev_id, pending);
        end
        tick();
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t2: valid=%b, expected 0", ev_valid);
        end
        din = '0;
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_event: got id=%0d edge=%b, expected id=%0d edge=%b", o.id, o.pol, e.id, e.pol);
            end
        end
    endtask

    task automatic test_simultaneous();
        ev_t e, o;
        apply_reset();
        ev_ready = 1'b1;
        din      = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 1'b1});
        tick();
        n_checks++;
        if (pending !== 4'b1111) begin
            n_fail++;
            $display("FAIL simul_pending: pending=%b, expected 1111", pending);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (ev_valid !== 1'b1 || ev_id !== 2'(k)) begin
                n_fail++;
                $display("FAIL simul_order: cycle %0d valid=%b id=%0d, expected 1/%0d", k, ev_valid, ev_id, k);
            end
        end
        tick();
        n_checks++;
        if (ev_valid !== 1'b0 || overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL simul_end: valid=%b overflow=%b, expected 0/0000", ev_valid, overflow);
        end
        din = '0;
        repeat (2) tick();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL simul_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL simul_event: got id=%0d edge=%b, expected id=%0d edge=%b", o.id, o.pol, e.id, e.pol);
            end
        end
    endtask

    task automatic test_backpressure();
        ev_t e, o;
        apply_reset();
        ev_ready = 1'b0;
        // Three rises on channel 1: one reaches the port, one pends, one is dropped.
        din = 4'b0010; tick();
        din = 4'b0000; tick();
        din = 4'b0010; tick();
        din = 4'b0000; tick();
        din = 4'b0010; tick();
        exp_q.push_back({2'd1, 1'b1});
        exp_q.push_back({2'd1, 1'b1});
        n_checks++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd1 || pending !== 4'b0010 || overflow !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b id=%0d pending=%b overflow=%b, expected 1/1/0010/0010",
                     ev_valid, ev_id, pending, overflow);
        end
        din = 4'b0000; tick();
        din     = 4'b0010;
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        n_checks++;
        if (overflow !== 4'b0010 || ev_valid !== 1'b1 || ev_id !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_set_over_clr: overflow=%b valid=%b id=%0d, expected 0010/1/1", overflow, ev_valid, ev_id);
        end
        ev_ready = 1'b1;
        tick();
        n_checks++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd1 || pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_second: valid=%b id=%0d pending=%b, expected 1/1/0000", ev_valid, ev_id, pending);
        end
        tick();
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: valid=%b, expected 0", ev_valid);
        end
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        n_checks++;
        if (overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_ovf_clr: overflow=%b, expected 0000", overflow);
        end
        din = '0;
        repeat (2) tick();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bp_event: got id=%0d edge=%b, expected id=%0d edge=%b", o.id, o.pol, e.id, e.pol);
            end
        end
    endtask

    task automatic test_fairness();
        ev_t e, o;
        apply_reset();
        ev_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back({2'd0, 1'b1});
            exp_q.push_back({2'd3, 1'b1});
            din = 4'b1001; tick();
            din = 4'b0000; tick();
        end
        repeat (4) tick();
        n_checks++;
        if (overflow !== 4'b0000 || ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fair_end: overflow=%b valid=%b, expected 0000/0", overflow, ev_valid);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL fair_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL fair_event: got id=%0d edge=%b, expected id=%0d edge=%b", o.id, o.pol, e.id, e.pol);
            end
        end
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        apply_reset();
        ev_ready = 1'b0;
        din = 4'b0010; tick();
        din = 4'b0000; tick();
        din = 4'b1010; tick();
        n_checks++;
        if (ev_valid !== 1'b1 || pending !== 4'b1010) begin
            n_fail++;
            $display("FAIL rmid_setup: valid=%b pending=%b, expected 1/1010", ev_valid, pending);
        end
        resetn = 1'b0;
        din    = 4'b0001;
        tick();
        n_checks++;
        if (ev_valid !== 1'b0 || ev_id !== 2'd0 || pending !== 4'b0000 || overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_cleared: valid=%b id=%0d pending=%b overflow=%b, expected 0/0/0000/0000",
                     ev_valid, ev_id, pending, overflow);
        end
        resetn   = 1'b1;
        ev_ready = 1'b1;
        exp_q.push_back({2'd0, 1'b1});
        tick();
        n_checks++;
        if (ev_valid !== 1'b0 || pending !== 4'b0001) begin
            n_fail++;
            $display("FAIL rmid_r1: valid=%b pending=%b, expected 0/0001", ev_valid, pending);
        end
        tick();
        n_checks++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_r2: valid=%b id=%0d, expected 1/0", ev_valid, ev_id);
        end
        din = '0;
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rmid_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rmid_event: got id=%0d edge=%b, expected id=%0d edge=%b", o.id, o.pol, e.id, e.pol);
            end
        end
    endtask

    task automatic test_both_edges();
        ev_t e, o;
        apply_reset();
        ev_ready = 1'b1;
        din      = 4'b0100;
        exp_q.push_back({2'd2, 1'b1});
        repeat (4) tick();
        din = 4'b0000;
`ifdef EDGE_ARB_BOTH_EN
        exp_q.push_back({2'd2, 1'b0});
`endif
        tick();
        tick();
        n_checks++;
`ifdef EDGE_ARB_BOTH_EN
        if (ev_valid !== 1'b1 || ev_id !== 2'd2 || ev_edge !== 1'b0) begin
            n_fail++;
            $display("FAIL both_fall: valid=%b id=%0d edge=%b, expected 1/2/0", ev_valid, ev_id, ev_edge);
        end
`else
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL both_fall: valid=%b after fall, expected 0", ev_valid);
        end
`endif
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL both_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL both_event: got id=%0d edge=%b, expected id=%0d edge=%b", o.id, o.pol, e.id, e.pol);
            end
        end
    endtask

    initial begin
        resetn   = 1'b0;
        din      = '0;
        ev_ready = 1'b0;
        ovf_clr  = '0;
        test_reset();
`ifndef EDGE_ARB_BOTH_EN
        test_single_rise();
        test_simultaneous();
        test_backpressure();
        test_fairness();
        test_reset_mid();
`endif
        test_both_edges();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event scheduler. It watches `N` asynchronous-to-software level inputs, registers a rising edge on each channel as a pending event, and serializes the events onto one valid/ready event port using round-robin arbitration. It sits between raw status lines (interrupt sources, sensor strobes) and a single downstream consumer such as an event FIFO or an interrupt controller. Events that cannot be held are reported as sticky per-channel overflow flags.

## Interface
- `N`, default 4: number of input channels, 2..16.
- `ID_W`, default 2: width of `ev_id`; `ID_W` = ceil(log2(N)).
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, synchronous, active-low. The clock is `clk`.
- `din`, in, N: level inputs; bit i is channel i.
- `ev_valid`, out, 1: an event is presented on the port.
- `ev_id`, out, ID_W: channel number of the presented event.
- `ev_edge`, out, 1: polarity of the presented event; 1 = rise, 0 = fall.
- `ev_ready`, in, 1: the consumer accepts the event.
- `pending`, out, N: per-channel pending flags; events waiting, not counting the one on the port.
- `overflow`, out, N: sticky per-channel flag; set when an event was dropped.
- `ovf_clr`, in, N: clears the matching `overflow` bits; one pulse per clear.

## Operation
- **Edge detect, per channel.** `prev[i]` holds `din[i]` sampled at the previous edge. `rise[i] = din[i] & ~prev[i]`.
- **Reset behaviour.** During reset `prev` is forced to 0, so `din` is treated as 0. A `din` bit that is high at the first edge after reset produces a rise event.
- **Pending.** `rise[i]` sets `pending[i]`. Loading channel i onto the port clears `pending[i]`.
  - If `rise[i]` arrives in the same cycle that channel i is loaded, `pending[i]` stays set. This is a new event.
  - If `rise[i]` arrives while `pending[i]` is already set and not being loaded, the event is dropped and `overflow[i]` is set.
- **Overflow clear.** Setting `overflow` has priority over a simultaneous `ovf_clr[i]`.
- **Arbiter.** Round-robin pointer `last`, reset to N-1, so channel 0 wins first.
  - The winner is the first set `pending` bit searching `last+1`, `last+2`, … modulo N.
  - `last` updates to the winner only when a load occurs.
- **Output register.** Loads when `!ev_valid || ev_ready` and any `pending` bit is set.
  - On load: `ev_valid = 1`, `ev_id = winner`, `ev_edge = stored polarity`.
  - If `ev_valid && ev_ready` and nothing is pending, `ev_valid` drops to 0.
  - Full throughput: one event per cycle under continuous `ev_ready`.
- **Handshake rules.**
  - `ev_valid` never deasserts without `ev_ready`.
  - `ev_id` and `ev_edge` stay stable while `ev_valid && !ev_ready`.
  - `ev_ready` may be high while `ev_valid` is low; it has no effect then.
- **Held events.** The port holds one event and each channel holds one pending event. A channel therefore buffers at most 2 events: one on the port, one pending.
- **Reset values.** `ev_valid=0`, `ev_id=0`, `ev_edge=1`, `pending=0`, `overflow=0`, `prev=0`, `last=N-1`.
- **Reset mid-operation.** All events, pending and on the port, are discarded. There is no partial handshake after reset.

## Timing
- Edge t is the first clock edge that samples `din[i]=1` with `prev[i]=0`.
  - `pending[i]` is visible after edge t.
  - `ev_valid` is visible after edge t+1, provided the port is free and channel i wins.
  - Minimum latency is 2 cycles.
- The handshake completes at the edge where `ev_valid && ev_ready`. The next event can be presented immediately after that same edge.
- `overflow` sets at edge t of the dropped rise. `ovf_clr` takes effect at the next edge.

## Configuration
- Macro: `EDGE_ARB_BOTH_EN`.
- **Defined:**
  - Falling edges (`~din[i] & prev[i]`) also create events.
  - Each channel stores the polarity of its pending event, and `ev_edge` reports it.
  - Any edge arriving while the channel's pending flag is set and not being loaded is an overflow, whatever its polarity.
- **Undefined:**
  - Only rises are detected.
  - `ev_edge` is the constant 1.
  - No polarity storage is built.

## Test plan
- **Single rise.** Reset, `ev_ready=1`, `din` goes 0000→0100 before edge t. Required: `pending=0100` after t; `ev_valid=1`, `ev_id=2` for exactly one cycle after t+1; then `pending=0`.
- **Simultaneous rise.** `din` goes 0000→1111 at one edge, `ev_ready=1`. Required: `ev_id` = 0, 1, 2, 3 on 4 consecutive cycles; `overflow=0`.
- **Backpressure.**
  - Setup: `ev_ready=0`; channel 1 rises 3 times, with `din` toggled 1,0,1,0,1.
  - Required while `ev_ready=0`: `ev_valid` held with `ev_id=1`; `pending[1]=1`; `overflow=0010`.
  - Required after `ev_ready=1`: `ev_id=1` twice, then idle.
  - Required after `ovf_clr=0010`: `overflow=0000`.
- **Fairness.** Channels 0 and 3 re-rise every 2 cycles, `ev_ready=1`. Required: grants alternate 0, 3, 0, 3, …; neither channel overflows.
- **Reset mid-operation.** `ev_valid=1` and `pending=1010`, then `resetn=0` for 1 cycle with `din=0001` held. Required: after reset everything is cleared; first event is `ev_id=0`, 2 cycles after release.
- **Both edges (`EDGE_ARB_BOTH_EN` defined).** Channel 2 goes 1→0, `ev_ready=1`. Required: `ev_id=2`, `ev_edge=0`. With the macro undefined: no event.
